frog_move_ctrl: RTL and testbench
=================================

// Module: frog_move_ctrl
// PURPOSE
// Player (frog) position controller, directly upstream of the sprite display stage. It debounces the
// four direction buttons and steps the frog one tile per press, with hold-to-repeat on frame ticks.
// Drives X_Position/Y_Position of the display stage, respawns the frog on a collision, and flags a level
// win when the top row is reached.
// PARAMETERS
// TILE_SIZE        32      step size in pixels; sprite width/height
// H_VISIBLE_AREA   640     visible width in pixels
// V_VISIBLE_AREA   480     visible height in pixels
// START_X          320     respawn X (multiple of TILE_SIZE)
// START_Y          448     respawn Y (V_VISIBLE_AREA - TILE_SIZE)
// DEBOUNCE_CYCLES  250000  consecutive stable samples before a button level is accepted (10 ms @ 25 MHz)
// REPEAT_FRAMES    12      frame ticks between repeated steps while a direction is held
// HIT_FRAMES       30      frame ticks the frog stays frozen after a collision
// PORTS
// i_Clk           in   1   pixel clock; sole clock
// i_Rst           in   1   synchronous, active-high reset
// i_Up            in   1   raw button, active high, asynchronous to i_Clk (2-FF synchronised inside)
// i_Down          in   1   raw button, as i_Up
// i_Left          in   1   raw button, as i_Up
// i_Right         in   1   raw button, as i_Up
// i_Frame_Tick    in   1   1-cycle pulse per frame (start of vertical blanking)
// i_Collision     in   1   frog/car overlap, level sensitive, sampled every cycle
// o_X_Position    out  10  frog left-corner X, registered
// o_Y_Position    out  10  frog top-corner Y, registered
// o_Level_Up      out  1   1-cycle pulse when the frog reaches Y = 0
// o_Hit           out  1   high while in state HIT
// BEHAVIOUR
// - Reset: o_X=START_X, o_Y=START_Y, o_Level_Up=0, o_Hit=0, state=PLAY, debounced levels=0,
//   debounce and repeat counters=0. Reset wins over every other event on the same edge.
// - Debounce per button: the counter clears whenever the synced sample equals the debounced level.
//   Otherwise it increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level flips and the counter clears.
// - Press = rising edge of a debounced level. If a button is held through reset, it registers as a press
//   once debounced.
// - One step per decision cycle. Priority Up > Down > Left > Right; lower-priority presses on the same
//   cycle are discarded.
// - Step: Up Y-=TILE_SIZE, Down Y+=TILE_SIZE, Left X-=TILE_SIZE, Right X+=TILE_SIZE.
// - Legal range: X in [0, H_VISIBLE_AREA-TILE_SIZE], Y in [0, V_VISIBLE_AREA-TILE_SIZE].
//   A step that leaves this range is dropped (no wrap, no partial step).
// - Latency: the position updates on the edge after the press is detected, i.e. the output changes
//   one cycle after the debounced level rises.
// - Hold-repeat: after a press, the repeat counter counts i_Frame_Tick while that same debounced level
//   stays high. At REPEAT_FRAMES it takes another step of the same direction and clears.
// - The repeat counter clears on any release or on any new press.
// FSM
// - PLAY -> HIT when i_Collision=1. Collision has priority over a step on the same cycle; position holds.
// - HIT: o_Hit=1; buttons are ignored but still debounced. After HIT_FRAMES frame ticks: position=START,
//   go to PLAY. i_Collision is ignored while in HIT.
// - PLAY -> WIN when a step lands on Y=0. The new Y=0 is output for one cycle with o_Level_Up=1.
// - WIN -> PLAY on the next cycle with position=START. Presses during WIN are discarded.
// - Arithmetic: compute in 11 bits so underflow below 0 and overflow past the edge are detected
//   before truncating to 10 bits.
// TESTING (sim params: DEBOUNCE_CYCLES=4, REPEAT_FRAMES=2, HIT_FRAMES=3, TILE_SIZE=32)
// - Reset, then Right pulse 2 cycles wide -> no move. Right held 6 cycles -> X 320->352 exactly once,
//   Y stays 448.
// - Down held from Y=448 -> step dropped, Y stays 448. Left from X=0 -> X stays 0.
// - Up held, 4 i_Frame_Tick -> Y 448->416 (press), ->384, ->352. Release -> no further step.
// - Up+Left debounced same cycle -> Y-=32 only, X unchanged.
// - i_Collision=1 at the same cycle as an Up press -> o_Hit=1, position frozen.
//   After 3 frame ticks -> (320,448), o_Hit=0.
// - Frog at Y=32, Up -> Y=0 with o_Level_Up=1 for exactly 1 cycle, then (320,448).
//   i_Rst mid-HIT -> reset values next cycle.

Source files
------------

// File: rtl/frog_move_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | frog_move_ctrl : debounced tile-stepping frog position with hit/win FSM  |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module frog_move_ctrl #(
  parameter int TILE_SIZE       = 32,
  parameter int H_VISIBLE_AREA  = 640,
  parameter int V_VISIBLE_AREA  = 480,
  parameter int START_X         = 320,
  parameter int START_Y         = 448,
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int REPEAT_FRAMES   = 12,
  parameter int HIT_FRAMES      = 30
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Up,
  input  logic       i_Down,
  input  logic       i_Left,
  input  logic       i_Right,
  input  logic       i_Frame_Tick,
  input  logic       i_Collision,
  output logic [9:0] o_X_Position,
  output logic [9:0] o_Y_Position,
  output logic       o_Level_Up,
  output logic       o_Hit
);

  localparam int c_DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int c_REP_W = (REPEAT_FRAMES > 1) ? $clog2(REPEAT_FRAMES) : 1;
  localparam int c_HIT_W = (HIT_FRAMES > 1) ? $clog2(HIT_FRAMES) : 1;

  localparam logic [10:0]        c_TILE    = 11'(TILE_SIZE);
  localparam logic [10:0]        c_X_MAX   = 11'(H_VISIBLE_AREA - TILE_SIZE);
  localparam logic [10:0]        c_Y_MAX   = 11'(V_VISIBLE_AREA - TILE_SIZE);
  localparam logic [9:0]         c_START_X = 10'(START_X);
  localparam logic [9:0]         c_START_Y = 10'(START_Y);
  localparam logic [c_DB_W-1:0]  c_DB_LAST  = c_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [c_REP_W-1:0] c_REP_LAST = c_REP_W'(REPEAT_FRAMES - 1);
  localparam logic [c_HIT_W-1:0] c_HIT_LAST = c_HIT_W'(HIT_FRAMES - 1);

  // Direction index: 0 = Up, 1 = Down, 2 = Left, 3 = Right (also the priority order)
  localparam logic [1:0] c_DIR_UP    = 2'd0;
  localparam logic [1:0] c_DIR_DOWN  = 2'd1;
  localparam logic [1:0] c_DIR_LEFT  = 2'd2;
  localparam logic [1:0] c_DIR_RIGHT = 2'd3;

  typedef enum logic [1:0] {
    S_PLAY = 2'd0,
    S_HIT  = 2'd1,
    S_WIN  = 2'd2
  } state_t;

  logic [3:0]         w_raw;
  logic [3:0]         r_sync1;
  logic [3:0]         r_sync2;
  logic [3:0]         w_db;
  logic [3:0]         r_db_prev;
  logic [3:0]         w_press;
  logic [3:0]         w_release;
  logic               w_press_any;
  logic [1:0]         w_press_dir;
  logic               w_rep_fire;
  logic               w_step_req;
  logic [1:0]         w_step_dir;
  logic [10:0]        w_nx;
  logic [10:0]        w_ny;
  logic               w_legal;

  state_t             r_state;
  logic [9:0]         r_x;
  logic [9:0]         r_y;
  logic               r_level_up;
  logic               r_hit;
  logic               r_rep_active;
  logic [1:0]         r_rep_dir;
  logic [c_REP_W-1:0] r_rep_cnt;
  logic [c_HIT_W-1:0] r_hit_cnt;

  assign w_raw = {i_Right, i_Left, i_Down, i_Up};

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_sync1 <= 4'b0;
      r_sync2 <= 4'b0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_btn
      logic [c_DB_W-1:0] r_cnt;
      logic              r_level;

      always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
          r_cnt   <= '0;
          r_level <= 1'b0;
        end else if (r_sync2[gi] == r_level) begin
          r_cnt <= '0;
        end else if (r_cnt == c_DB_LAST) begin
          r_cnt   <= '0;
          r_level <= ~r_level;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      assign w_db[gi] = r_level;
    end
  endgenerate

  assign w_press     = w_db & ~r_db_prev;
  assign w_release   = ~w_db & r_db_prev;
  assign w_press_any = |w_press;

  always_comb begin
    w_press_dir = c_DIR_RIGHT;
    if (w_press[0])      w_press_dir = c_DIR_UP;
    else if (w_press[1]) w_press_dir = c_DIR_DOWN;
    else if (w_press[2]) w_press_dir = c_DIR_LEFT;
  end

  assign w_rep_fire = r_rep_active && w_db[r_rep_dir] && i_Frame_Tick && (r_rep_cnt == c_REP_LAST);
  assign w_step_req = w_press_any || w_rep_fire;
  assign w_step_dir = w_press_any ? w_press_dir : r_rep_dir;

  // 11-bit math: a step below zero wraps far above the limit, so one compare catches both edges
  always_comb begin
    w_nx = {1'b0, r_x};
    w_ny = {1'b0, r_y};
    case (w_step_dir)
      c_DIR_UP:    w_ny = {1'b0, r_y} - c_TILE;
      c_DIR_DOWN:  w_ny = {1'b0, r_y} + c_TILE;
      c_DIR_LEFT:  w_nx = {1'b0, r_x} - c_TILE;
      default:     w_nx = {1'b0, r_x} + c_TILE;
    endcase
    w_legal = (w_nx <= c_X_MAX) && (w_ny <= c_Y_MAX);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      r_state      <= S_PLAY;
      r_x          <= c_START_X;
      r_y          <= c_START_Y;
      r_level_up   <= 1'b0;
      r_hit        <= 1'b0;
      r_db_prev    <= 4'b0;
      r_rep_active <= 1'b0;
      r_rep_dir    <= c_DIR_UP;
      r_rep_cnt    <= '0;
      r_hit_cnt    <= '0;
    end else begin
      r_db_prev  <= w_db;
      r_level_up <= 1'b0;
      case (r_state)
        S_PLAY: begin
          if (i_Collision) begin
            r_state      <= S_HIT;
            r_hit        <= 1'b1;
            r_hit_cnt    <= '0;
            r_rep_active <= 1'b0;
            r_rep_cnt    <= '0;
          end else begin
            if (w_press_any) begin
              r_rep_active <= 1'b1;
              r_rep_dir    <= w_press_dir;
              r_rep_cnt    <= '0;
            end else if (!w_db[r_rep_dir]) begin
              r_rep_active <= 1'b0;
              r_rep_cnt    <= '0;
            end else if (|w_release) begin
              r_rep_cnt <= '0;
            end else if (r_rep_active && i_Frame_Tick) begin
              r_rep_cnt <= w_rep_fire ? '0 : r_rep_cnt + 1'b1;
            end

            if (w_step_req && w_legal) begin
              r_x <= w_nx[9:0];
              r_y <= w_ny[9:0];
              if (w_ny == 11'd0) begin
                r_state      <= S_WIN;
                r_level_up   <= 1'b1;
                r_rep_active <= 1'b0;
                r_rep_cnt    <= '0;
              end
            end
          end
        end

        S_HIT: begin
          r_rep_active <= 1'b0;
          r_rep_cnt    <= '0;
          if (i_Frame_Tick) begin
            if (r_hit_cnt == c_HIT_LAST) begin
              r_state   <= S_PLAY;
              r_hit     <= 1'b0;
              r_hit_cnt <= '0;
              r_x       <= c_START_X;
              r_y       <= c_START_Y;
            end else begin
              r_hit_cnt <= r_hit_cnt + 1'b1;
            end
          end
        end

        S_WIN: begin
          r_state      <= S_PLAY;
          r_x          <= c_START_X;
          r_y          <= c_START_Y;
          r_rep_active <= 1'b0;
          r_rep_cnt    <= '0;
        end

        default: begin
          r_state <= S_PLAY;
        end
      endcase
    end
  end

  assign o_X_Position = r_x;
  assign o_Y_Position = r_y;
  assign o_Level_Up   = r_level_up;
  assign o_Hit        = r_hit;

endmodule
`default_nettype wire

// File: tb/tb_frog_move_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_frog_move_ctrl : directed + randomized checks of frog_move_ctrl        |
// | Revision 1.0                                                             |
// +--------------------------------------------------------------------------+
module tb_frog_move_ctrl;

  localparam int c_TILE   = 32;
  localparam int c_REP    = 2;
  localparam int c_XMAX   = 640 - 32;
  localparam int c_YMAX   = 480 - 32;
  localparam int c_STARTX = 320;
  localparam int c_STARTY = 448;

  logic       clk = 1'b0;
  logic       rst;
  logic       up, down, left, right;
  logic       tick, coll;
  logic [9:0] xpos, ypos;
  logic       lvl_up, hit;

  int tests = 0;
  int fails = 0;
  int mx, my;

  always #5 clk = ~clk;

  frog_move_ctrl #(
    .TILE_SIZE       (32),
    .H_VISIBLE_AREA  (640),
    .V_VISIBLE_AREA  (480),
    .START_X         (320),
    .START_Y         (448),
    .DEBOUNCE_CYCLES (4),
    .REPEAT_FRAMES   (2),
    .HIT_FRAMES      (3)
  ) dut (
    .i_Clk        (clk),
    .i_Rst        (rst),
    .i_Up         (up),
    .i_Down       (down),
    .i_Left       (left),
    .i_Right      (right),
    .i_Frame_Tick (tick),
    .i_Collision  (coll),
    .o_X_Position (xpos),
    .o_Y_Position (ypos),
    .o_Level_Up   (lvl_up),
    .o_Hit        (hit)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_n(input int n);
    repeat (n) cyc();
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_btn(input int d, input logic v);
    case (d)
      0: up    = v;
      1: down  = v;
      2: left  = v;
      default: right = v;
    endcase
  endtask

  task automatic pulse_tick();
    tick = 1'b1;
    cyc();
    tick = 1'b0;
    wait_n(2);
  endtask

  // Position after one press held across k frame ticks: 1 + k/REPEAT steps,
  // off-screen steps dropped, landing on the top row respawns and ends the hold.
  task automatic model_hold(input int d, input int k);
    int nx, ny;
    for (int s = 0; s < 1 + k / c_REP; s++) begin
      nx = mx;
      ny = my;
      case (d)
        0: ny = my - c_TILE;
        1: ny = my + c_TILE;
        2: nx = mx - c_TILE;
        default: nx = mx + c_TILE;
      endcase
      if (nx >= 0 && nx <= c_XMAX && ny >= 0 && ny <= c_YMAX) begin
        mx = nx;
        my = ny;
        if (my == 0) begin
          mx = c_STARTX;
          my = c_STARTY;
          break;
        end
      end
    end
  endtask

  task automatic hold(input int d, input int k);
    set_btn(d, 1'b1);
    wait_n(12);
    repeat (k) pulse_tick();
    set_btn(d, 1'b0);
    wait_n(12);
    model_hold(d, k);
  endtask

  initial begin
    int d, k;
    rst = 1'b1; up = 1'b0; down = 1'b0; left = 1'b0; right = 1'b0;
    tick = 1'b0; coll = 1'b0;
    wait_n(3);
    chk("reset_x", 32'(xpos), 320);
    chk("reset_y", 32'(ypos), 448);
    chk("reset_hit", 32'(hit), 0);
    chk("reset_lvl", 32'(lvl_up), 0);
    rst = 1'b0;
    mx = c_STARTX;
    my = c_STARTY;
    cyc();

    // Too-short pulse must not survive the debouncer
    right = 1'b1;
    wait_n(2);
    right = 1'b0;
    wait_n(10);
    chk("short_pulse_x", 32'(xpos), 320);

    // Six-cycle hold: exactly one step, one cycle after the level is accepted
    right = 1'b1;
    wait_n(6);
    right = 1'b0;
    chk("right_before_x", 32'(xpos), 320);
    cyc();
    chk("right_step_x", 32'(xpos), 352);
    chk("right_step_y", 32'(ypos), 448);
    wait_n(10);
    chk("right_once_x", 32'(xpos), 352);
    mx = 352;

    hold(1, 2);
    chk("down_edge_y", 32'(ypos), 448);
    hold(2, 20);
    chk("left_to_zero_x", 32'(xpos), 0);
    hold(2, 4);
    chk("left_edge_x", 32'(xpos), 0);
    hold(3, 18);
    chk("back_right_x", 32'(xpos), 320);

    // Hold-repeat on frame ticks
    up = 1'b1;
    wait_n(7);
    chk("up_press_y", 32'(ypos), 416);
    pulse_tick();
    pulse_tick();
    chk("up_rep1_y", 32'(ypos), 384);
    pulse_tick();
    pulse_tick();
    chk("up_rep2_y", 32'(ypos), 352);
    up = 1'b0;
    wait_n(12);
    repeat (4) pulse_tick();
    chk("up_release_y", 32'(ypos), 352);

    // Simultaneous Up+Left: only Up acts
    up = 1'b1;
    left = 1'b1;
    wait_n(12);
    up = 1'b0;
    left = 1'b0;
    wait_n(12);
    chk("prio_y", 32'(ypos), 320);
    chk("prio_x", 32'(xpos), 320);

    // Collision on the decision cycle of an Up press
    up = 1'b1;
    wait_n(6);
    coll = 1'b1;
    cyc();
    coll = 1'b0;
    chk("hit_flag", 32'(hit), 1);
    chk("hit_freeze_y", 32'(ypos), 320);
    up = 1'b0;
    pulse_tick();
    pulse_tick();
    chk("hit_still", 32'(hit), 1);
    chk("hit_still_y", 32'(ypos), 320);
    pulse_tick();
    chk("hit_done", 32'(hit), 0);
    chk("hit_respawn_x", 32'(xpos), 320);
    chk("hit_respawn_y", 32'(ypos), 448);
    mx = c_STARTX;
    my = c_STARTY;

    // Climb to Y=32 then win
    hold(0, 24);
    chk("climb_y", 32'(ypos), 32'(my));
    chk("climb_y_const", 32'(ypos), 32);
    up = 1'b1;
    wait_n(6);
    chk("pre_win_lvl", 32'(lvl_up), 0);
    cyc();
    chk("win_y", 32'(ypos), 0);
    chk("win_lvl", 32'(lvl_up), 1);
    cyc();
    chk("win_after_lvl", 32'(lvl_up), 0);
    chk("win_after_x", 32'(xpos), 320);
    chk("win_after_y", 32'(ypos), 448);
    up = 1'b0;
    wait_n(12);
    chk("win_held_y", 32'(ypos), 448);
    mx = c_STARTX;
    my = c_STARTY;

    // Reset in the middle of HIT
    hold(3, 0);
    chk("pre_rst_x", 32'(xpos), 352);
    coll = 1'b1;
    cyc();
    coll = 1'b0;
    chk("pre_rst_hit", 32'(hit), 1);
    cyc();
    rst = 1'b1;
    cyc();
    chk("rst_hit", 32'(hit), 0);
    chk("rst_x", 32'(xpos), 320);
    chk("rst_y", 32'(ypos), 448);
    rst = 1'b0;
    mx = c_STARTX;
    my = c_STARTY;
    cyc();

    // Randomized holds against the arithmetic model
    for (int it = 0; it < 25; it++) begin
      d = int'($urandom_range(0, 3));
      k = int'($urandom_range(0, 6));
      hold(d, k);
      chk("rand_x", 32'(xpos), 32'(mx));
      chk("rand_y", 32'(ypos), 32'(my));
    end
    chk("final_hit", 32'(hit), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire
